// File: rtl/bus_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter: state encoding,
// default hold limit and the rotating priority search.
package bus_arbiter8_pkg;

  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Scans from the highest offset down so the lowest offset from ptr wins last.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    pick_t      p;
    logic [2:0] k;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      k = ptr + 3'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bus_arbiter8_dec.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module bus_arbiter8_dec (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  assign onehot = en ? (8'b1 << idx) : 8'b0;

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for one shared bus: one-cycle grant latency, hold limit
// with timeout pulse, and a mandatory one-cycle turnaround gap after release.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;

  pick_t      pick;
  logic       owner_release;
  logic       at_limit;

  assign pick          = rr_pick(req, ptr_q);
  assign owner_release = done || !req[idx_q];
  assign at_limit      = (hold_q == HOLD_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          state_d = ST_BUSY;
          idx_d   = pick.idx;
          ptr_d   = pick.idx + 3'd1;
          hold_d  = '0;
        end
      end
      ST_BUSY: begin
        if (owner_release || at_limit) begin
          // Always fall back to IDLE for one turnaround cycle, even with requests pending.
          state_d   = ST_IDLE;
          idx_d     = '0;
          hold_d    = '0;
          timeout_d = at_limit && !owner_release;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == ST_BUSY);
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

  bus_arbiter8_dec u_dec (
    .idx    (idx_q),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_bus_arbiter8.sv
// Scoreboard bench for bus_arbiter8: directed scenarios plus random req/done,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_bus_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner (-1 = nobody), pointer, cycles owned so far, timeout flag.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  bus_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] q, input logic d);
    int  c;
    bit  drop;
    bit  lim;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          c = (m_ptr + k) % 8;
          if (q[c]) begin
            m_owner = c;
            break;
          end
        end
        m_ptr  = (m_owner + 1) % 8;
        m_held = 1;
      end
    end else begin
      drop = d || !q[m_owner];
      lim  = (m_held == MAX_HOLD);
      if (drop || lim) begin
        m_to    = lim && !drop;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_to = 1'b0;
        m_held++;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] q, input logic d);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = q;
    done = d;
    model_step(r, q, d);
    e.valid   = (m_owner >= 0);
    e.idx     = e.valid ? 3'(m_owner) : 3'd0;
    e.gnt     = e.valid ? (8'b1 << e.idx) : 8'h00;
    e.timeout = m_to;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each registered output set against the scoreboard entry,
  // and checks structural invariants on the DUT outputs themselves.
  initial begin
    exp_t       e;
    int         run      = 0;
    logic       prev_v   = 1'b0;
    logic [2:0] prev_idx = 3'd0;
    logic [7:0] want_gnt;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {19'd0, gnt, gnt_idx, gnt_valid, timeout}, {19'd0, e});
      end
      want_gnt = gnt_valid ? (8'b1 << gnt_idx) : 8'h00;
      check("onehot", {24'd0, gnt}, {24'd0, want_gnt});
      if (gnt_valid) begin
        run = (prev_v && gnt_idx == prev_idx) ? run + 1 : 1;
        check("hold_len_ok", {31'd0, run <= MAX_HOLD}, 32'd1);
      end else begin
        run = 0;
        check("idx_zero_idle", {29'd0, gnt_idx}, 32'd0);
      end
      prev_v   = gnt_valid;
      prev_idx = gnt_idx;
    end
  end

  initial begin
    logic [7:0] cur_req;
    int         guard;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset state.
    drive(1, 8'h00, 0);
    drive(1, 8'hFF, 1);

    // Single requester holds for three cycles, then drops.
    drive(0, 8'h01, 0);
    drive(0, 8'h01, 0);
    drive(0, 8'h01, 0);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);

    // All requesting, done pulsed: owners rotate 0..7,0 with gaps.
    drive(1, 8'h00, 0);
    repeat (18) drive(0, 8'hFF, 1);

    // Hold limit: requester 3 never releases.
    drive(1, 8'h00, 0);
    repeat (12) drive(0, 8'h08, 0);

    // Owner 2 keeps the bus while requester 5 waits.
    drive(1, 8'h00, 0);
    drive(0, 8'h04, 0);
    drive(0, 8'h24, 0);
    drive(0, 8'h24, 0);
    drive(0, 8'h24, 1);
    drive(0, 8'h24, 0);
    drive(0, 8'h24, 0);
    drive(0, 8'h00, 0);

    // Reset during owner 6 busy, then search restarts from pointer 0.
    drive(1, 8'h00, 0);
    drive(0, 8'h40, 0);
    drive(0, 8'h40, 0);
    drive(1, 8'hC0, 0);
    drive(0, 8'hC0, 0);
    drive(0, 8'hC0, 1);
    drive(0, 8'h00, 0);

    // Random traffic with sticky requests so hold limits are reached.
    cur_req = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur_req = 8'h00;
          1:       cur_req = 8'b1 << $urandom_range(0, 7);
          default: cur_req = 8'($urandom);
        endcase
      end
      drive(($urandom_range(0, 499) == 0), cur_req, ($urandom_range(0, 7) == 0));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
